// File: rtl/ram_arb_pkg.sv
// ==== ram_arb_pkg: shared types and constants for ram_arbiter (rev 1.0) ====
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ==== rr_arb2: two-way round-robin arbiter, one-hot grant (rev 1.0) ====
`default_nettype none

module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_winner;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // On a tie the requester that did not win last time goes first
        2'b11:   gnt = (last_winner == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner <= REQ_B;
    end else if (gnt[0]) begin
      last_winner <= REQ_A;
    end else if (gnt[1]) begin
      last_winner <= REQ_B;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ==== ram_arbiter: serializes two requesters onto single-port ram1 (rev 1.0) ====
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [15:0]       ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int CNT_W = 2;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             arb_en;

  // Grants are suppressed while reset is held so every output reads 0 at once
  assign arb_en = (state == IDLE) && reset_n;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .enable  (arb_en),
    .gnt     (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign busy  = (state != IDLE) || (|gnt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = ACCESS;
      ACCESS:  state_nxt = ram_we ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= REQ_A;
      cnt      <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner    <= gnt[1] ? REQ_B : REQ_A;
            ram_we   <= gnt[1] ? b_we : a_we;
            ram_addr <= 16'(gnt[1] ? b_addr : a_addr);
            ram_din  <= gnt[1] ? b_wdata : a_wdata;
          end
        end
        ACCESS: cnt <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            if (owner == REQ_B) begin
              b_rdata  <= ram_dout;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= ram_dout;
              a_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ==== tb_ram_arbiter: directed + random checks against a transaction-level model (rev 1.0) ====
`default_nettype none

module tb_ram_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        do_init = 1'b1;

  // Main DUT (RD_LAT=1)
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [7:0]  a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we1, busy1;
  logic [15:0] a_rdata, b_rdata, ram_addr1, ram_din1, ram_dout1;

  // Second DUT (RD_LAT=3)
  logic        a3_req = 0, a3_we = 0, b3_req = 0, b3_we = 0;
  logic [7:0]  a3_addr = 0, b3_addr = 0;
  logic [15:0] a3_wdata = 0, b3_wdata = 0;
  logic        a3_gnt, a3_rvalid, b3_gnt, b3_rvalid, ram_we3, busy3;
  logic [15:0] a3_rdata, b3_rdata, ram_addr3, ram_din3, ram_dout3;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
    .ram_dout(ram_dout1), .busy(busy1)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
    .a_gnt(a3_gnt), .a_rvalid(a3_rvalid), .a_rdata(a3_rdata),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_gnt(b3_gnt), .b_rvalid(b3_rvalid), .b_rdata(b3_rdata),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3),
    .ram_dout(ram_dout3), .busy(busy3)
  );

  function automatic logic [15:0] pre(int i);
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  // ram1 models: 256x16, read latency 1 and 3
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] p3_0, p3_1;

  always @(posedge clk) begin
    if (do_init) for (int i = 0; i < 256; i++) mem1[i] <= pre(i);
    else if (ram_we1) mem1[ram_addr1[7:0]] <= ram_din1;
    ram_dout1 <= mem1[ram_addr1[7:0]];
  end

  always @(posedge clk) begin
    if (do_init) for (int i = 0; i < 256; i++) mem3[i] <= pre(i);
    else if (ram_we3) mem3[ram_addr3[7:0]] <= ram_din3;
    p3_0      <= mem3[ram_addr3[7:0]];
    p3_1      <= p3_0;
    ram_dout3 <= p3_1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next-cycle stimulus, applied 1ns after each rising edge
  logic        n_rst = 0;
  logic        n_a_req = 0, n_a_we = 0, n_b_req = 0, n_b_we = 0;
  logic [7:0]  n_a_addr = 0, n_b_addr = 0;
  logic [15:0] n_a_wdata = 0, n_b_wdata = 0;

  // Transaction-level model: occupancy window, fairness bit, shadow memory
  int          cyc = 0;
  int          free_cyc = 0;
  bit          m_last_b = 1;
  logic [15:0] smem [256];
  int          rv_cyc = -1;
  bit          rv_own = 0;
  logic [15:0] rv_data = 0;
  logic [15:0] m_ardata = 0, m_brdata = 0, m_addr = 0, m_din = 0;
  int          acc_cyc = -1;
  bit          acc_we = 0;
  logic [15:0] acc_addr = 0, acc_din = 0;

  task automatic model();
    bit       idle;
    bit       own;
    bit       we;
    logic [1:0] eg;
    logic [7:0] ad;
    cyc++;
    if (!reset_n) begin
      chk("rst_a_gnt", a_gnt, 0);     chk("rst_b_gnt", b_gnt, 0);
      chk("rst_busy", busy1, 0);      chk("rst_ram_we", ram_we1, 0);
      chk("rst_ram_addr", ram_addr1, 0); chk("rst_ram_din", ram_din1, 0);
      chk("rst_a_rvalid", a_rvalid, 0);  chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);    chk("rst_b_rdata", b_rdata, 0);
      free_cyc = 0; m_last_b = 1; rv_cyc = -1; acc_cyc = -1;
      m_ardata = 0; m_brdata = 0; m_addr = 0; m_din = 0;
      return;
    end
    idle = (cyc >= free_cyc);
    eg = 2'b00;
    if (idle) begin
      if (a_req && (!b_req || m_last_b)) eg = 2'b01;
      else if (b_req) eg = 2'b10;
    end
    chk("a_gnt", a_gnt, eg[0]);
    chk("b_gnt", b_gnt, eg[1]);
    chk("busy", busy1, !idle || (eg != 2'b00));
    if (cyc == rv_cyc) begin
      if (rv_own) m_brdata = rv_data; else m_ardata = rv_data;
    end
    chk("a_rvalid", a_rvalid, (cyc == rv_cyc) && !rv_own);
    chk("b_rvalid", b_rvalid, (cyc == rv_cyc) && rv_own);
    chk("a_rdata", a_rdata, m_ardata);
    chk("b_rdata", b_rdata, m_brdata);
    if (cyc == acc_cyc) begin
      m_addr = acc_addr;
      m_din  = acc_din;
    end
    chk("ram_we", ram_we1, (cyc == acc_cyc) && acc_we);
    chk("ram_addr", ram_addr1, m_addr);
    chk("ram_din", ram_din1, m_din);
    if (eg != 2'b00) begin
      own      = eg[1];
      we       = own ? b_we : a_we;
      ad       = own ? b_addr : a_addr;
      acc_din  = own ? b_wdata : a_wdata;
      acc_addr = {8'h00, ad};
      acc_we   = we;
      acc_cyc  = cyc + 1;
      m_last_b = own;
      if (we) begin
        smem[ad] = acc_din;
        free_cyc = cyc + 2;
      end else begin
        rv_cyc   = cyc + LAT + 2;
        rv_own   = own;
        rv_data  = smem[ad];
        free_cyc = cyc + LAT + 2;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset_n = n_rst;
    a_req = n_a_req; a_we = n_a_we; a_addr = n_a_addr; a_wdata = n_a_wdata;
    b_req = n_b_req; b_we = n_b_we; b_addr = n_b_addr; b_wdata = n_b_wdata;
    @(negedge clk);
    model();
    if (a_gnt) n_a_req = 0;
    if (b_gnt) n_b_req = 0;
  endtask

  task automatic cmd_a(input logic we, input logic [7:0] ad, input logic [15:0] wd);
    n_a_req = 1; n_a_we = we; n_a_addr = ad; n_a_wdata = wd;
  endtask

  task automatic cmd_b(input logic we, input logic [7:0] ad, input logic [15:0] wd);
    n_b_req = 1; n_b_we = we; n_b_addr = ad; n_b_wdata = wd;
  endtask

  initial begin
    int rv3_at;
    int rv3_cnt;
    int busy3_cnt;
    for (int i = 0; i < 256; i++) smem[i] = pre(i);

    // Reset held, RAM preload on first edge
    step();
    do_init = 0;
    step();
    n_rst = 1;
    step();

    // A writes 12AB to 05, then reads it back
    cmd_a(1, 8'h05, 16'h12AB);
    for (int k = 0; k < 4; k++) step();
    cmd_a(0, 8'h05, 16'h0000);
    for (int k = 0; k < 5; k++) step();
    chk("a_readback_05", a_rdata, 16'h12AB);

    // Both read continuously: grants must alternate
    for (int k = 0; k < 16; k++) begin
      cmd_a(0, 8'h10, 16'h0);
      cmd_b(0, 8'h20, 16'h0);
      step();
    end
    n_a_req = 0; n_b_req = 0;
    for (int k = 0; k < 6; k++) step();
    chk("b_rdata_20", b_rdata, pre(8'h20));

    // A reads 30 first, B writes FFFF there, A reads again
    cmd_a(0, 8'h30, 16'h0);
    step();
    cmd_b(1, 8'h30, 16'hFFFF);
    for (int k = 0; k < 6; k++) step();
    chk("a_old_30", a_rdata, pre(8'h30));
    cmd_a(0, 8'h30, 16'h0);
    for (int k = 0; k < 5; k++) step();
    chk("a_new_30", a_rdata, 16'hFFFF);

    // Reset during WAIT of an A read, then a tie must go to A
    cmd_a(0, 8'h05, 16'h0);
    step(); step(); step();
    n_rst = 0;
    step();
    n_rst = 1;
    cmd_a(0, 8'h07, 16'h0);
    cmd_b(0, 8'h08, 16'h0);
    step();
    chk("tie_after_reset_a", a_gnt, 1);
    for (int k = 0; k < 10; k++) step();

    // RD_LAT=3 instance: read 01, rvalid 5 cycles after gnt, busy 5 cycles
    @(posedge clk); #1;
    a3_req = 1; a3_we = 0; a3_addr = 8'h01;
    @(negedge clk);
    model();
    chk("l3_gnt", a3_gnt, 1);
    busy3_cnt = busy3 ? 1 : 0;
    rv3_at = -1; rv3_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      a3_req = 0;
      @(negedge clk);
      model();
      if (busy3) busy3_cnt++;
      if (a3_rvalid) begin rv3_cnt++; rv3_at = k; end
    end
    chk("l3_rvalid_at", rv3_at, 5);
    chk("l3_rvalid_cnt", rv3_cnt, 1);
    chk("l3_busy_cycles", busy3_cnt, 5);
    chk("l3_rdata", a3_rdata, pre(8'h01));
    chk("l3_b_rvalid", b3_rvalid, 0);

    // Random traffic, small address range to hit read-after-write
    for (int k = 0; k < 400; k++) begin
      if (!n_a_req) begin
        if ($urandom_range(0, 2) != 0)
          cmd_a(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 7)), 16'($urandom));
      end else if ($urandom_range(0, 15) == 0) begin
        n_a_req = 0;
      end
      if (!n_b_req) begin
        if ($urandom_range(0, 2) != 0)
          cmd_b(1'($urandom_range(0, 4) == 0), 8'($urandom_range(0, 7)), 16'($urandom));
      end else if ($urandom_range(0, 15) == 0) begin
        n_b_req = 0;
      end
      step();
    end
    n_a_req = 0; n_b_req = 0;
    for (int k = 0; k < 8; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and access sequencer for the 256x16 single-port block RAM wrapper (ram1).
- Requester A is the user switch/debounce path (writes and readback). Requester B is the 7-segment display scan path (reads only, but writes are legal).
- Issues one RAM access at a time with round-robin fairness.
- Returns read data to the requester that issued the read.

Parameters:
- ADDR_W, 8, RAM address width; upper bits of ram_addr are driven 0.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from the address-sampling edge to valid ram_dout (1..3).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A command valid; held until a_gnt.
- a_we  in  1  A command type: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A command accepted this cycle (combinational from state and requests).
- a_rvalid  out  1  one-cycle pulse; a_rdata valid.
- a_rdata  out  DATA_W  A read data; held until A's next read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for requester B.
- ram_we  out  1  to ram1 we.
- ram_addr  out  16  to ram1 addr; bits [15:ADDR_W] = 0.
- ram_din  out  DATA_W  to ram1 din.
- ram_dout  in  DATA_W  from ram1 dout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; ram_we=0, ram_addr=0, ram_din=0.
  - a_/b_rvalid=0, a_/b_rdata=0.
  - last_winner=B, so A wins the first tie.
  - An in-flight access is dropped silently; no rvalid for it after reset release.
- Handshake:
  - A transfer occurs in a cycle where x_req && x_gnt.
  - gnt is asserted only in IDLE and to at most one requester per cycle.
  - The requester may change or drop req in the cycle after gnt.
  - req deasserted before gnt is legal and withdraws the command.
- Arbitration (IDLE):
  - Only one requester: grant it.
  - Both requesting: grant the one that is not last_winner.
  - last_winner updates on each grant.
- FSM:
  - IDLE: on grant, register we/addr/wdata into ram_we/ram_addr/ram_din and the owner id -> ACCESS. No request -> stay in IDLE with ram_we=0.
  - ACCESS (1 cycle): RAM samples the command at the end of this cycle. Write -> IDLE; ram_we is high for exactly this one cycle. Read -> WAIT with cnt=RD_LAT-1.
  - WAIT: ram_we=0. When cnt==0, capture ram_dout into the owner's rdata and set the owner's rvalid for the next cycle, then -> IDLE. Otherwise decrement cnt.
  - ram_addr and ram_din hold their last values outside ACCESS.
- Latency at RD_LAT=1:
  - Read: gnt cycle T, rvalid at T+3.
  - Write: RAM written at end of T+1; next grant possible at T+2.
  - A read takes RD_LAT+2 cycles of occupancy.
- rvalid overlaps IDLE, so a new grant may occur in the same cycle as rvalid.
- Read-after-write to the same address by either requester returns the new data, because accesses are strictly serialized.
- rvalid for the other requester is never asserted; rdata of the non-owner is unchanged.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE, ACCESS, WAIT), requester-id constants (REQ_A=0, REQ_B=1), default ADDR_W/DATA_W.
- One sub-module, rr_arb2: 2-way round-robin arbiter holding last_winner. Inputs: req[1:0], enable. Outputs: one-hot gnt[1:0].
- Everything else stays in ram_arbiter.

Test Plan:
- Reset, then A writes 16'h12AB to addr 8'h05 -> a_gnt one cycle; ram_we=1 for one cycle with ram_addr=16'h0005, ram_din=16'h12AB; busy high for 2 cycles.
- A reads addr 8'h05 after that write -> a_rvalid pulses 3 cycles after a_gnt with a_rdata=16'h12AB; b_rvalid stays 0.
- Both A and B request reads (addr 8'h10, 8'h20) continuously, starting from reset -> grants alternate A, B, A, B; each rdata matches the preloaded contents; no cycle has both gnt high.
- B writes 16'hFFFF to 8'h30 while A reads 8'h30, A granted first -> A gets the old value; A's next read returns 16'hFFFF.
- RD_LAT=3 build: read of 8'h01 -> rvalid 5 cycles after gnt; busy high for 5 cycles.
- reset_n pulsed low during WAIT of an A read -> all outputs 0 immediately; no a_rvalid after release; the next tied request is granted to A.
